button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 12 +
 rtl/btn_debounce_one.sv | 118 +++++++++++
 rtl/button_conditioner.sv | 34 +++
 tb/tb_button_conditioner.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner slice.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_t;

  localparam int unsigned NUM_BTN_DEFAULT = 5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of the raw button inputs and the conditioned level/pulse outputs.
interface button_conditioner_if #(
  parameter int unsigned NUM_BTN = btn_cond_pkg::NUM_BTN_DEFAULT
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (output btn_in, input btn_level, btn_press, btn_release);
  modport slave  (input btn_in, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_debounce_one.sv
// One button channel: 2-flop synchronizer, debounce FSM, registered pulses.
// Optional auto-repeat of the press pulse is compiled in with BTN_REPEAT_EN.
module btn_debounce_one
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The PEND entry cycle already counts as the first stable sample.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic            meta;
  logic            sync;
  btn_state_t      state;
  logic [CW-1:0]   cnt;

`ifdef BTN_REPEAT_EN
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          first;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef BTN_REPEAT_EN
      rcnt  <= '0;
      first <= 1'b1;
`endif
    end else begin
      meta  <= btn;
      sync  <= meta;
      press <= 1'b0;
      rel   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_PEND;
            cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
`ifdef BTN_REPEAT_EN
            rcnt  <= '0;
            first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= REL_PEND;
            cnt   <= '0;
          end
`ifdef BTN_REPEAT_EN
          else if (rcnt == (first ? DELAY_LAST : PERIOD_LAST)) begin
            press <= 1'b1;
            rcnt  <= '0;
            first <= 1'b0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
`endif
        end
        REL_PEND: begin
          if (sync) begin
            state <= HELD;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rcnt  <= '0;
            first <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent debounce channel per button.
// Define BTN_REPEAT_EN to enable auto-repeat press pulses while a button is held.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_one #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (CLK),
      .rst  (RST),
      .btn  (BTN_IN[i]),
      .level(BTN_LEVEL[i]),
      .press(BTN_PRESS[i]),
      .rel  (BTN_RELEASE[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4).
module tb_button_conditioner;

  localparam int unsigned NB = 5;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  button_conditioner_if #(.NUM_BTN(NB)) bif ();

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_IN     (bif.btn_in),
    .BTN_LEVEL  (bif.btn_level),
    .BTN_PRESS  (bif.btn_press),
    .BTN_RELEASE(bif.btn_release)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [NB-1:0] z;
    z = '0;
    bif.btn_in = '1;
    repeat (3) tick();
    if (bif.btn_level !== z) begin n_fail++; $display("FAIL reset_level got %b want %b", bif.btn_level, z); end
    n_checks++;
    if (bif.btn_press !== z) begin n_fail++; $display("FAIL reset_press got %b want %b", bif.btn_press, z); end
    n_checks++;
    if (bif.btn_release !== z) begin n_fail++; $display("FAIL reset_release got %b want %b", bif.btn_release, z); end
    n_checks++;
    bif.btn_in = '0;
    RST = 1'b0;
    repeat (8) tick();
    if (bif.btn_level !== z) begin n_fail++; $display("FAIL post_reset_level got %b want %b", bif.btn_level, z); end
    n_checks++;
  endtask

  task automatic test_clean_press();
    logic [NB-1:0] ep, el;
    bif.btn_in = 5'b00001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (k == 6) ? 5'b00001 : 5'b00000;
      el = (k >= 6) ? 5'b00001 : 5'b00000;
      if (bif.btn_press !== ep) begin n_fail++; $display("FAIL press_clean k=%0d got %b want %b", k, bif.btn_press, ep); end
      n_checks++;
      if (bif.btn_level !== el) begin n_fail++; $display("FAIL level_clean k=%0d got %b want %b", k, bif.btn_level, el); end
      n_checks++;
      if (bif.btn_release !== 5'b00000) begin n_fail++; $display("FAIL release_clean k=%0d got %b want 00000", k, bif.btn_release); end
      n_checks++;
    end
  endtask

  task automatic test_bounce();
    logic [NB-1:0] pat [4];
    pat[0] = 5'b00011; pat[1] = 5'b00001; pat[2] = 5'b00011; pat[3] = 5'b00001;
    for (int k = 0; k < 14; k++) begin
      bif.btn_in = (k < 4) ? pat[k] : 5'b00001;
      tick();
      if (bif.btn_press !== 5'b00000) begin n_fail++; $display("FAIL press_bounce k=%0d got %b want 00000", k, bif.btn_press); end
      n_checks++;
      if (bif.btn_level !== 5'b00001) begin n_fail++; $display("FAIL level_bounce k=%0d got %b want 00001", k, bif.btn_level); end
      n_checks++;
    end
  endtask

  task automatic test_release();
    logic [NB-1:0] er, el;
    bif.btn_in = 5'b00000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      er = (k == 6) ? 5'b00001 : 5'b00000;
      el = (k < 6) ? 5'b00001 : 5'b00000;
      if (bif.btn_release !== er) begin n_fail++; $display("FAIL release k=%0d got %b want %b", k, bif.btn_release, er); end
      n_checks++;
      if (bif.btn_level !== el) begin n_fail++; $display("FAIL level_release k=%0d got %b want %b", k, bif.btn_level, el); end
      n_checks++;
      if (bif.btn_press !== 5'b00000) begin n_fail++; $display("FAIL press_release k=%0d got %b want 00000", k, bif.btn_press); end
      n_checks++;
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] ep;
    bif.btn_in = 5'b10010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (k == 6) ? 5'b10010 : 5'b00000;
      if (bif.btn_press !== ep) begin n_fail++; $display("FAIL press_simul k=%0d got %b want %b", k, bif.btn_press, ep); end
      n_checks++;
    end
    bif.btn_in = 5'b00000;
    repeat (8) tick();
    if (bif.btn_level !== 5'b00000) begin n_fail++; $display("FAIL level_simul_off got %b want 00000", bif.btn_level); end
    n_checks++;
  endtask

  task automatic test_debounce_boundary();
    logic [NB-1:0] ep, er, el;
    // One cycle short of the debounce window: rejected.
    bif.btn_in = 5'b10000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) bif.btn_in = 5'b00000;
      if (bif.btn_press !== 5'b00000 || bif.btn_level !== 5'b00000) begin
        n_fail++; $display("FAIL short_pulse k=%0d got press %b level %b want 00000", k, bif.btn_press, bif.btn_level);
      end
      n_checks++;
    end
    // Exactly the debounce window: accepted, then released.
    bif.btn_in = 5'b10000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) bif.btn_in = 5'b00000;
      ep = (k == 6) ? 5'b10000 : 5'b00000;
      er = (k == 10) ? 5'b10000 : 5'b00000;
      el = (k >= 6 && k < 10) ? 5'b10000 : 5'b00000;
      if (bif.btn_press !== ep) begin n_fail++; $display("FAIL press_min k=%0d got %b want %b", k, bif.btn_press, ep); end
      n_checks++;
      if (bif.btn_release !== er) begin n_fail++; $display("FAIL release_min k=%0d got %b want %b", k, bif.btn_release, er); end
      n_checks++;
      if (bif.btn_level !== el) begin n_fail++; $display("FAIL level_min k=%0d got %b want %b", k, bif.btn_level, el); end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [NB-1:0] ep, el;
    bif.btn_in = 5'b00100;
    repeat (7) tick();
    if (bif.btn_level !== 5'b00100) begin n_fail++; $display("FAIL level_prehold got %b want 00100", bif.btn_level); end
    n_checks++;
    RST = 1'b1;
    #1;
    if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 15'd0) begin
      n_fail++; $display("FAIL async_reset got %b/%b/%b want all zero", bif.btn_level, bif.btn_press, bif.btn_release);
    end
    n_checks++;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bif.btn_release !== 5'b00000) begin n_fail++; $display("FAIL release_in_reset k=%0d got %b want 00000", k, bif.btn_release); end
      n_checks++;
    end
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (k == 6) ? 5'b00100 : 5'b00000;
      el = (k >= 6) ? 5'b00100 : 5'b00000;
      if (bif.btn_press !== ep) begin n_fail++; $display("FAIL press_after_reset k=%0d got %b want %b", k, bif.btn_press, ep); end
      n_checks++;
      if (bif.btn_level !== el) begin n_fail++; $display("FAIL level_after_reset k=%0d got %b want %b", k, bif.btn_level, el); end
      n_checks++;
      if (bif.btn_release !== 5'b00000) begin n_fail++; $display("FAIL release_after_reset k=%0d got %b want 00000", k, bif.btn_release); end
      n_checks++;
    end
    bif.btn_in = 5'b00000;
    repeat (8) tick();
  endtask

  task automatic test_repeat();
    logic [NB-1:0] ep, er, el;
    bit            rep;
    bif.btn_in = 5'b01000;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 19) bif.btn_in = 5'b00000;
`ifdef BTN_REPEAT_EN
      rep = (k == 6 || k == 16 || k == 19);
`else
      rep = (k == 6);
`endif
      ep = rep ? 5'b01000 : 5'b00000;
      er = (k == 25) ? 5'b01000 : 5'b00000;
      el = (k >= 6 && k < 25) ? 5'b01000 : 5'b00000;
      if (bif.btn_press !== ep) begin n_fail++; $display("FAIL press_repeat k=%0d got %b want %b", k, bif.btn_press, ep); end
      n_checks++;
      if (bif.btn_release !== er) begin n_fail++; $display("FAIL release_repeat k=%0d got %b want %b", k, bif.btn_release, er); end
      n_checks++;
      if (bif.btn_level !== el) begin n_fail++; $display("FAIL level_repeat k=%0d got %b want %b", k, bif.btn_level, el); end
      n_checks++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    RST        = 1'b1;
    bif.btn_in = '0;
    @(negedge CLK);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_debounce_boundary();
    test_reset_mid_hold();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
